// File: rtl/adpll_freq_ctrl.sv
// ADPLL frequency-acquisition and lock controller (SAR coarse search, +/-1 fine tracking).
// Define ADPLL_FREQ_CTRL_SKIP_COARSE_EN to start from INIT_CODE and skip the SAR phase.
module adpll_freq_ctrl #(
  parameter int              CODE_W     = 8,
  parameter int              CNT_W      = 32,
  parameter int              LOCK_TOL   = 2,
  parameter int              UNLOCK_TOL = 6,
  parameter int              LOCK_COUNT = 4,
  parameter int              TIMEOUT    = 1024,
  parameter logic [CODE_W-1:0] INIT_CODE = 8'h80
) (
  input  logic              i_F_clk,
  input  logic              i_Reset,
  input  logic              i_En,
  input  logic [CNT_W-1:0]  i_Target_ratio,
  input  logic [CNT_W-1:0]  i_C_freq,
  input  logic              i_Meas_valid,
  output logic              o_Meas_en,
  output logic              o_Meas_reset,
  output logic [CODE_W-1:0] o_DCO_code,
  output logic              o_Busy,
  output logic              o_Locked,
  output logic              o_Fail
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int LW = $clog2(LOCK_COUNT + 1);
`ifndef ADPLL_FREQ_CTRL_SKIP_COARSE_EN
  localparam int BW = (CODE_W > 1) ? $clog2(CODE_W) : 1;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESTART,
    S_DISCARD,
    S_MEASURE,
`ifndef ADPLL_FREQ_CTRL_SKIP_COARSE_EN
    S_COARSE_UPD,
`endif
    S_FINE_UPD,
    S_LOCKED,
    S_FAIL
  } state_t;

  state_t             r_state;
  logic [CODE_W-1:0]  r_code;
  logic [CNT_W-1:0]   r_target;
  logic [CNT_W-1:0]   r_cfreq;
  logic [LW-1:0]      r_lock_cnt;
  logic [TW-1:0]      r_tmo;
  logic               r_meas_en;
  logic               r_meas_reset;
  logic               r_locked;
  logic               r_fail;
`ifndef ADPLL_FREQ_CTRL_SKIP_COARSE_EN
  logic [BW-1:0]      r_bit;
  logic               r_fine;
`endif

  logic [CNT_W-1:0]   w_meas;
  logic [CNT_W:0]     w_err;
  logic [CNT_W:0]     w_abs;
  logic               w_up;
  logic               w_sat;
  logic [CODE_W-1:0]  w_step_code;
  logic               w_in_lock;
  logic               w_out_lock;
  logic               w_tmo_hit;

  // LOCKED evaluates the live result; FINE_UPD uses the captured one
  assign w_meas = (r_state == S_LOCKED) ? i_C_freq : r_cfreq;
  assign w_err  = {1'b0, w_meas} - {1'b0, r_target};
  assign w_abs  = w_err[CNT_W] ? (~w_err + 1'b1) : w_err;
  assign w_up   = w_err[CNT_W];

  assign w_in_lock  = (w_abs <= (CNT_W+1)'(LOCK_TOL));
  assign w_out_lock = (w_abs >  (CNT_W+1)'(UNLOCK_TOL));

  assign w_sat       = w_up ? (&r_code) : (r_code == '0);
  assign w_step_code = w_up ? (r_code + 1'b1) : (r_code - 1'b1);
  assign w_tmo_hit   = (r_tmo == TW'(TIMEOUT - 1));

  always_ff @(posedge i_F_clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_state      <= S_IDLE;
      r_code       <= '0;
      r_target     <= '0;
      r_cfreq      <= '0;
      r_lock_cnt   <= '0;
      r_tmo        <= '0;
      r_meas_en    <= 1'b0;
      r_meas_reset <= 1'b0;
      r_locked     <= 1'b0;
      r_fail       <= 1'b0;
`ifndef ADPLL_FREQ_CTRL_SKIP_COARSE_EN
      r_bit        <= BW'(CODE_W - 1);
      r_fine       <= 1'b0;
`endif
    end else begin
      r_meas_reset <= 1'b0;
      if (!i_En) begin
        r_state   <= S_IDLE;
        r_locked  <= 1'b0;
        r_fail    <= 1'b0;
        r_meas_en <= 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            r_target     <= i_Target_ratio;
            r_lock_cnt   <= '0;
            r_meas_en    <= 1'b1;
            r_meas_reset <= 1'b1;
            r_state      <= S_RESTART;
`ifdef ADPLL_FREQ_CTRL_SKIP_COARSE_EN
            r_code       <= INIT_CODE;
`else
            r_code       <= {1'b1, {(CODE_W-1){1'b0}}};
            r_bit        <= BW'(CODE_W - 1);
            r_fine       <= 1'b0;
`endif
          end

          S_RESTART: begin
            r_tmo   <= '0;
            r_state <= S_DISCARD;
          end

          // this window straddles the code change, so its result is dropped
          S_DISCARD: begin
            if (i_Meas_valid) begin
              r_tmo   <= '0;
              r_state <= S_MEASURE;
            end else if (w_tmo_hit) begin
              r_fail    <= 1'b1;
              r_locked  <= 1'b0;
              r_meas_en <= 1'b0;
              r_state   <= S_FAIL;
            end else begin
              r_tmo <= r_tmo + 1'b1;
            end
          end

          S_MEASURE: begin
            if (i_Meas_valid) begin
              r_cfreq <= i_C_freq;
              r_tmo   <= '0;
`ifdef ADPLL_FREQ_CTRL_SKIP_COARSE_EN
              r_state <= S_FINE_UPD;
`else
              r_state <= r_fine ? S_FINE_UPD : S_COARSE_UPD;
`endif
            end else if (w_tmo_hit) begin
              r_fail    <= 1'b1;
              r_locked  <= 1'b0;
              r_meas_en <= 1'b0;
              r_state   <= S_FAIL;
            end else begin
              r_tmo <= r_tmo + 1'b1;
            end
          end

`ifndef ADPLL_FREQ_CTRL_SKIP_COARSE_EN
          S_COARSE_UPD: begin
            if (r_cfreq > r_target) r_code[r_bit] <= 1'b0;
            if (r_bit != '0) begin
              r_bit                  <= r_bit - 1'b1;
              r_code[r_bit - 1'b1]   <= 1'b1;
            end else begin
              r_fine <= 1'b1;
            end
            r_meas_reset <= 1'b1;
            r_state      <= S_RESTART;
          end
`endif

          S_FINE_UPD: begin
            if (w_in_lock) begin
              if (r_lock_cnt == LW'(LOCK_COUNT - 1)) begin
                r_lock_cnt <= LW'(LOCK_COUNT);
                r_locked   <= 1'b1;
                r_state    <= S_LOCKED;
              end else begin
                r_lock_cnt <= r_lock_cnt + 1'b1;
                r_state    <= S_MEASURE;
              end
            end else begin
              r_lock_cnt <= '0;
              if (w_sat) begin
                r_state <= S_MEASURE;
              end else begin
                r_code       <= w_step_code;
                r_meas_reset <= 1'b1;
                r_state      <= S_RESTART;
              end
            end
          end

          S_LOCKED: begin
            if (i_Meas_valid) begin
              r_tmo <= '0;
              if (w_out_lock) begin
                r_locked   <= 1'b0;
                r_lock_cnt <= '0;
                if (w_sat) begin
                  r_state <= S_MEASURE;
                end else begin
                  r_code       <= w_step_code;
                  r_meas_reset <= 1'b1;
                  r_state      <= S_RESTART;
                end
              end
            end else if (w_tmo_hit) begin
              r_fail    <= 1'b1;
              r_locked  <= 1'b0;
              r_meas_en <= 1'b0;
              r_state   <= S_FAIL;
            end else begin
              r_tmo <= r_tmo + 1'b1;
            end
          end

          S_FAIL: begin
            r_state <= S_FAIL;
          end

          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign o_Meas_en    = r_meas_en;
  assign o_Meas_reset = r_meas_reset;
  assign o_DCO_code   = r_code;
  assign o_Locked     = r_locked;
  assign o_Fail       = r_fail;
  assign o_Busy       = !((r_state == S_IDLE) ||
                          (r_state == S_LOCKED) ||
                          (r_state == S_FAIL));

endmodule

// File: tb/tb_adpll_freq_ctrl.sv
// Bench for adpll_freq_ctrl: emulated ratio counter (C_freq = 4*code + offset)
// and an arithmetic reference for the expected restart-code sequence.
module tb_adpll_freq_ctrl;

  localparam int CODE_W     = 8;
  localparam int CNT_W      = 32;
  localparam int LOCK_TOL   = 2;
  localparam int UNLOCK_TOL = 6;
  localparam int LOCK_COUNT = 4;
  localparam int TIMEOUT    = 1024;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en  = 1'b0;
  logic [CNT_W-1:0]  target = '0;
  logic [CNT_W-1:0]  cfreq  = '0;
  logic              mvalid = 1'b0;
  logic              meas_en;
  logic              meas_reset;
  logic [CODE_W-1:0] code;
  logic              busy;
  logic              locked;
  logic              fail;

  always #5 clk = ~clk;

  adpll_freq_ctrl #(
    .CODE_W(CODE_W), .CNT_W(CNT_W), .LOCK_TOL(LOCK_TOL),
    .UNLOCK_TOL(UNLOCK_TOL), .LOCK_COUNT(LOCK_COUNT),
    .TIMEOUT(TIMEOUT), .INIT_CODE(8'h80)
  ) dut (
    .i_F_clk(clk), .i_Reset(rst), .i_En(en),
    .i_Target_ratio(target), .i_C_freq(cfreq),
    .i_Meas_valid(mvalid), .o_Meas_en(meas_en),
    .o_Meas_reset(meas_reset), .o_DCO_code(code),
    .o_Busy(busy), .o_Locked(locked), .o_Fail(fail)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int period = 6;
  int offset = 0;
  int vcnt   = 0;
  int wcnt   = 0;
  int win    = 0;
  bit suppress = 1'b0;
  int rq[$];
  int exp_q[$];
  int exp_final;
  bit exp_lock;

  // Ratio counter emulation: restart on Meas_reset, pulse every few cycles
  initial forever begin
    @(negedge clk);
    mvalid = 1'b0;
    if (meas_reset) begin
      rq.push_back(int'(code));
      wcnt = 0;
      win  = 0;
      vcnt = 0;
    end else if (meas_en && !suppress) begin
      wcnt++;
      if (wcnt >= period) begin
        wcnt   = 0;
        period = $urandom_range(12, 4);
        mvalid = 1'b1;
        vcnt++;
        if (win == 0) cfreq = $urandom;
        else          cfreq = 32'(4 * int'(code) + offset);
        win++;
      end
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic void fine_from(input int start, input int tgt);
    int c;
    c = start;
    for (int i = 0; i < 400; i++) begin
      int e;
      e = 4 * c + offset - tgt;
      if (iabs(e) <= LOCK_TOL) break;
      if (e > 0) begin
        if (c == 0) break;
        c--;
      end else begin
        if (c == 255) break;
        c++;
      end
      exp_q.push_back(c);
    end
    exp_final = c;
    exp_lock  = (iabs(4 * c + offset - tgt) <= LOCK_TOL);
  endfunction

  function automatic void build_acq(input int tgt);
    exp_q.delete();
`ifdef ADPLL_FREQ_CTRL_SKIP_COARSE_EN
    exp_q.push_back(128);
    fine_from(128, tgt);
`else
    begin
      int c;
      c = 0;
      for (int b = 7; b >= 0; b--) begin
        int t;
        t = c | (1 << b);
        exp_q.push_back(t);
        if (4 * t + offset <= tgt) c = t;
      end
      exp_q.push_back(c);
      fine_from(c, tgt);
    end
`endif
  endfunction

  task automatic compare_q(input string tag);
    int n;
    check({tag, "_nrestart"}, rq.size(), exp_q.size());
    n = (rq.size() < exp_q.size()) ? rq.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_code%0d", tag, i), rq[i], exp_q[i]);
  endtask

  task automatic wait_locked(input bit val, input int budget,
                             input string tag, output int vseen);
    int k;
    k = 0;
    while (locked !== val && k < budget) begin
      @(negedge clk);
      k++;
    end
    vseen = vcnt;
    check({tag, "_reached"}, int'(locked === val), 1);
  endtask

  task automatic go_idle();
    en = 1'b0;
    repeat (3) @(negedge clk);
    rq.delete();
  endtask

  task automatic acquire(input int tgt, input string tag);
    int vs;
    offset = 0;
    build_acq(tgt);
    target = tgt;
    en = 1'b1;
    repeat (25) @(negedge clk);
    target = $urandom;
    wait_locked(1'b1, 20000, tag, vs);
    check({tag, "_valids"}, vs, LOCK_COUNT + 1);
    check({tag, "_code"}, int'(code), exp_final);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_measen"}, int'(meas_en), 1);
    compare_q(tag);
  endtask

  initial begin
    int vs;
    int k;

    repeat (3) @(negedge clk);
    check("rst_code", int'(code), 0);
    check("rst_measen", int'(meas_en), 0);
    check("rst_measrst", int'(meas_reset), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_fail", int'(fail), 0);
    check("rst_busy", int'(busy), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    acquire(488, "acq488");

    offset = 8;
    rq.delete();
    wait_locked(1'b0, 200, "unlock", vs);
    exp_q.delete();
    fine_from(122, 488);
    wait_locked(1'b1, 20000, "relock", vs);
    check("relock_valids", vs, LOCK_COUNT + 1);
    check("relock_code", int'(code), exp_final);
    compare_q("relock");

    for (int r = 0; r < 3; r++) begin
      go_idle();
      check("idle_locked", int'(locked), 0);
      check("idle_busy", int'(busy), 0);
      acquire($urandom_range(1000, 8), $sformatf("rand%0d", r));
    end

    go_idle();
    offset = 0;
    build_acq(5000);
    target = 5000;
    en = 1'b1;
    k = 0;
    while (rq.size() < exp_q.size() && k < 20000) begin
      @(negedge clk);
      k++;
    end
    repeat (400) @(negedge clk);
    compare_q("sat");
    check("sat_code", int'(code), 255);
    check("sat_locked", int'(locked), 0);
    check("sat_busy", int'(busy), 1);
    check("sat_exp_lock", int'(exp_lock), 0);

    go_idle();
    suppress = 1'b1;
    target = 488;
    en = 1'b1;
    k = 0;
    while (meas_reset !== 1'b1 && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("tmo_restart", int'(meas_reset), 1);
    k = 0;
    while (fail !== 1'b1 && k < TIMEOUT + 50) begin
      @(negedge clk);
      k++;
    end
    check("tmo_cycles", k - 1, TIMEOUT);
    check("tmo_fail", int'(fail), 1);
    check("tmo_measen", int'(meas_en), 0);
    check("tmo_locked", int'(locked), 0);
    check("tmo_busy", int'(busy), 0);
    repeat (20) @(negedge clk);
    check("tmo_hold", int'(fail), 1);
    en = 1'b0;
    @(negedge clk);
    check("tmo_clear", int'(fail), 0);
    suppress = 1'b0;
    repeat (2) @(negedge clk);
    rq.delete();
    acquire(488, "after_tmo");

    go_idle();
    target = 488;
    en = 1'b1;
    k = 0;
    while (rq.size() < 4 && k < 5000) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_code", int'(code), 0);
    check("arst_measen", int'(meas_en), 0);
    check("arst_measrst", int'(meas_reset), 0);
    check("arst_locked", int'(locked), 0);
    check("arst_fail", int'(fail), 0);
    check("arst_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    rq.delete();
    target = 488;
    rst = 1'b0;
    acquire(488, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
